// File: rtl/regfile_mp_sb.sv
// rtl/regfile_mp_sb.sv - multi-read, dual-write register file with busy scoreboard
// Port 1 (memory writeback) wins write collisions and bypass priority over port 0 (ALU).
module regfile_mp_sb #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     any_busy
);

  localparam logic [ADDR_W:0] depthLim = (ADDR_W + 1)'(DEPTH);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [DEPTH-1:0]             busy;
  logic [DEPTH-1:0]             wrHit0, wrHit1, rsvHit;

  // Addresses that name real, writable storage; out-of-range and the zero register are excluded.
  function automatic logic addrLive(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < depthLim) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_comb begin
    wrHit0 = '0;
    wrHit1 = '0;
    rsvHit = '0;
    for (int r = 0; r < DEPTH; r++) begin
      if (!((ZERO_REG != 0) && (r == 0))) begin
        wrHit0[r] = we0    && (waddr0   == ADDR_W'(r));
        wrHit1[r] = we1    && (waddr1   == ADDR_W'(r));
        rsvHit[r] = rsv_en && (rsv_addr == ADDR_W'(r));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem  <= '0;
      busy <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (wrHit1[r])      mem[r] <= wdata1;
        else if (wrHit0[r]) mem[r] <= wdata0;
        // A reserve on the same edge as a write means a newer producer was issued.
        if (rsvHit[r])                   busy[r] <= 1'b1;
        else if (wrHit0[r] || wrHit1[r]) busy[r] <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : gRd
    logic [ADDR_W-1:0] a;
    logic              ok, byp0, byp1;

    assign a    = raddr[i*ADDR_W +: ADDR_W];
    assign ok   = !rst && addrLive(a);
    assign byp1 = (BYPASS != 0) && we1 && (waddr1 == a);
    assign byp0 = (BYPASS != 0) && we0 && (waddr0 == a);

    assign rdata[i*DATA_W +: DATA_W] = !ok  ? '0     :
                                       byp1 ? wdata1 :
                                       byp0 ? wdata0 : mem[a];
    assign rbusy[i] = ok && !byp1 && !byp0 && busy[a];
  end

  assign any_busy = |busy;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb/tb_regfile_mp_sb.sv - directed bench for regfile_mp_sb across three configurations
// dut0: bypass on, depth 32; dut1: bypass off, depth 32; dut2: bypass on, depth 24.
module tb_regfile_mp_sb;

  localparam int NCFG = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [2*AW-1:0] raddr;
  logic          we0, we1, rsv_en;
  logic [AW-1:0] waddr0, waddr1, rsv_addr;
  logic [DW-1:0] wdata0, wdata1;

  logic [2*DW-1:0] rdataD [NCFG];
  logic [1:0]      rbusyD [NCFG];
  logic            anyD   [NCFG];

  int cfgDepth  [NCFG] = '{32, 32, 24};
  int cfgBypass [NCFG] = '{1, 0, 1};

  logic [DW-1:0] mMem  [NCFG][32];
  bit            mBusy [NCFG][32];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_mp_sb #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)) dut0 (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdataD[0]), .rbusy(rbusyD[0]),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .any_busy(anyD[0]));

  regfile_mp_sb #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .BYPASS(0), .ZERO_REG(1)) dut1 (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdataD[1]), .rbusy(rbusyD[1]),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .any_busy(anyD[1]));

  regfile_mp_sb #(.DATA_W(32), .DEPTH(24), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)) dut2 (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdataD[2]), .rbusy(rbusyD[2]),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .any_busy(anyD[2]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clearModel();
    for (int d = 0; d < NCFG; d++)
      for (int r = 0; r < 32; r++) begin
        mMem[d][r]  = '0;
        mBusy[d][r] = 1'b0;
      end
  endtask

  function automatic bit writable(input int d, input int a);
    return (a != 0) && (a < cfgDepth[d]);
  endfunction

  function automatic bit bypassHit(input int d, input int a);
    return (cfgBypass[d] != 0) && ((we1 && int'(waddr1) == a) || (we0 && int'(waddr0) == a));
  endfunction

  function automatic logic [DW-1:0] expRead(input int d, input int a);
    if (rst || !writable(d, a)) return '0;
    if (cfgBypass[d] != 0 && we1 && int'(waddr1) == a) return wdata1;
    if (cfgBypass[d] != 0 && we0 && int'(waddr0) == a) return wdata0;
    return mMem[d][a];
  endfunction

  function automatic logic expBusy(input int d, input int a);
    if (rst || !writable(d, a) || bypassHit(d, a)) return 1'b0;
    return mBusy[d][a];
  endfunction

  function automatic logic expAny(input int d);
    for (int r = 0; r < 32; r++) if (mBusy[d][r]) return 1'b1;
    return 1'b0;
  endfunction

  // Model: apply port 0, then port 1 over it, then the reserve, each on legal addresses only.
  always @(posedge clk or posedge rst) begin
    if (rst) clearModel();
    else begin
      for (int d = 0; d < NCFG; d++) begin
        if (we0 && writable(d, int'(waddr0))) begin
          mMem[d][waddr0] = wdata0;
          mBusy[d][waddr0] = 1'b0;
        end
        if (we1 && writable(d, int'(waddr1))) begin
          mMem[d][waddr1] = wdata1;
          mBusy[d][waddr1] = 1'b0;
        end
        if (rsv_en && writable(d, int'(rsv_addr))) mBusy[d][rsv_addr] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < NCFG; d++) begin
      for (int p = 0; p < 2; p++) begin
        check($sformatf("cyc_rdata_d%0d_p%0d", d, p), 64'(rdataD[d][p*DW +: DW]),
              64'(expRead(d, int'(raddr[p*AW +: AW]))));
        check($sformatf("cyc_rbusy_d%0d_p%0d", d, p), 64'(rbusyD[d][p]),
              64'(expBusy(d, int'(raddr[p*AW +: AW]))));
      end
      check($sformatf("cyc_any_busy_d%0d", d), 64'(anyD[d]), 64'(expAny(d)));
    end
  end

  task automatic idle();
    we0 = 0; we1 = 0; rsv_en = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic setRd(input int a0, input int a1);
    raddr = {AW'(a1), AW'(a0)};
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    clearModel();
    rst = 1; idle(); raddr = '0;
    waddr0 = '0; waddr1 = '0; rsv_addr = '0; wdata0 = '0; wdata1 = '0;
    #12;
    check("reset_rdata", rdataD[0], 64'h0);
    check("reset_any_busy", 64'(anyD[0]), 64'h0);
    @(posedge clk); #1; rst = 0;

    // Write r5 and reserve r12, then read r5 on both ports.
    we0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF; rsv_en = 1; rsv_addr = 12;
    step();
    setRd(5, 5);
    #1;
    check("wr_r5_both_ports", rdataD[0], 64'hDEADBEEF_DEADBEEF);
    check("rsv_r12_any_busy", 64'(anyD[0]), 64'h1);

    // Asynchronous reset mid-cycle, plus an ignored write while held.
    #1; rst = 1;
    #1;
    for (int d = 0; d < NCFG; d++) begin
      check($sformatf("async_rst_rdata_d%0d", d), rdataD[d], 64'h0);
      check($sformatf("async_rst_rbusy_d%0d", d), 64'(rbusyD[d]), 64'h0);
      check($sformatf("async_rst_any_d%0d", d), 64'(anyD[d]), 64'h0);
    end
    we0 = 1; waddr0 = 5; wdata0 = 32'h1;
    @(posedge clk); #1; rst = 0; idle();
    #1;
    check("post_rst_r5", rdataD[0], 64'h0);

    // Bypass visibility before the edge vs. bypass-off.
    we1 = 1; waddr1 = 7; wdata1 = 32'h1234; setRd(7, 0);
    #1;
    check("bypass_on_r7", 64'(rdataD[0][31:0]), 64'h1234);
    check("bypass_off_r7", 64'(rdataD[1][31:0]), 64'h0);
    step();
    check("bypass_off_r7_after", 64'(rdataD[1][31:0]), 64'h1234);

    // Write collision and zero register.
    we0 = 1; waddr0 = 3; wdata0 = 32'h1; we1 = 1; waddr1 = 3; wdata1 = 32'h2;
    step();
    setRd(3, 0); #1;
    check("collision_r3", rdataD[0], 64'h0000_0000_0000_0002);
    we0 = 1; waddr0 = 0; wdata0 = 32'hFFFF;
    step();
    setRd(0, 0); #1;
    check("zero_reg_r0", rdataD[0], 64'h0);

    // Scoreboard: reserve, clear with bypass, and set-wins collision.
    rsv_en = 1; rsv_addr = 9; setRd(9, 9);
    step(); #1;
    check("rsv_r9_rbusy", 64'(rbusyD[0]), 64'h3);
    check("rsv_r9_any", 64'(anyD[0]), 64'h1);
    we0 = 1; waddr0 = 9; wdata0 = 32'h99; #1;
    check("wr_r9_bypass_rbusy", 64'(rbusyD[0]), 64'h0);
    check("wr_r9_nobypass_rbusy", 64'(rbusyD[1]), 64'h3);
    step(); #1;
    check("wr_r9_cleared", 64'(rbusyD[1]), 64'h0);
    check("wr_r9_any", 64'(anyD[2]), 64'h0);
    we1 = 1; waddr1 = 9; wdata1 = 32'h77; rsv_en = 1; rsv_addr = 9;
    step(); #1;
    check("rsv_wr_same_edge", 64'(rbusyD[0]), 64'h3);
    we0 = 1; waddr0 = 9; wdata0 = 32'h88;
    step();

    // Out-of-range on the depth-24 instance.
    we0 = 1; waddr0 = 30; wdata0 = 32'h5555; rsv_en = 1; rsv_addr = 30;
    step();
    setRd(30, 30); #1;
    check("oor_rdata_d2", rdataD[2], 64'h0);
    check("oor_rbusy_d2", 64'(rbusyD[2]), 64'h0);
    check("oor_any_d2", 64'(anyD[2]), 64'h0);
    check("r30_rdata_d0", rdataD[0], 64'h0000_5555_0000_5555);
    check("r30_any_d0", 64'(anyD[0]), 64'h1);
    for (int a = 0; a < 24; a++) begin
      setRd(a, 23 - a);
      step();
    end
    setRd(3, 7); #1;
    check("d2_r3_r7_intact", rdataD[2], 64'h0000_1234_0000_0002);
    we0 = 1; waddr0 = 30; wdata0 = 32'h0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
